md_unit: RTL and testbench

- Execute-stage multiply/divide unit for the MIPS pipeline.
- Runs MULT/MULTU/DIV/DIVU iteratively and owns the architectural HI/LO registers.
- Its HI/LO outputs feed the execute/memory pipeline register (HI_E/LO_E). Its busy output feeds the hazard unit, which stalls MFHI/MFLO and further MD ops.
- Supports an exception flush that cancels an in-flight op without touching HI/LO.

---
 rtl/md_pkg.sv | 27 ++
 rtl/md_unit_div_core.sv | 50 +++++
 rtl/md_unit.sv | 156 +++++++++++++++
 tb/tb_md_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, FSM states and helpers for the multiply/divide unit
// Contents:
//   MD_* op codes driven on md_unit.op
//   md_state_e   FSM state encoding
//   md_mag()     magnitude of an operand, optionally treating it as signed
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } md_state_e;

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_unit_div_core.sv
// rtl/md_unit_div_core.sv - restoring shift/subtract divider datapath, one quotient bit per step
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load             capture dividend/divisor magnitudes, clear remainder
//   step             perform one restoring iteration
//   dividend,divisor unsigned magnitudes
//   quo, rem         running quotient and remainder magnitudes
module div_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] quo_q, rem_q, dvs_q;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] diff;

  // After shifting, the partial remainder can briefly need 33 bits; when the
  // trial subtraction succeeds the result always fits back into 32.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    diff   = rem_sh[31:0] - dvs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= {quo_q[30:0], ge};
      rem_q <= ge ? diff : rem_sh[31:0];
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   start, op      issue strobe and op code (md_pkg::MD_*)
//   A, B           rs / rt operands
//   cancel         exception flush; aborts an in-flight op, drops a start in IDLE
//   busy           operation in flight
//   HI, LO         architectural HI/LO registers
module md_unit
  import md_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  // Counter holds either MUL_LAT-1 or the 31 remaining divide iterations.
  localparam int CNT_W = $clog2((MUL_LAT > 32) ? MUL_LAT : 32);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               msgn_q, msgn_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               div_load, div_step;
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic               is_div;

  // Sign-extending both operands to 64 bits and keeping the low 64 bits of the
  // product yields the correct signed or unsigned result from one multiplier.
  always_comb begin
    a_ext   = {{WIDTH{msgn_q & a_q[WIDTH-1]}}, a_q};
    b_ext   = {{WIDTH{msgn_q & b_q[WIDTH-1]}}, b_q};
    product = a_ext * b_ext;
  end

  assign is_div = (op == MD_DIV);

  div_core u_div_core (
    .clk      (clk),
    .rst_n    (reset),
    .load     (div_load),
    .step     (div_step),
    .dividend (md_mag(A, is_div)),
    .divisor  (md_mag(B, is_div)),
    .quo      (quo),
    .rem      (rem)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    msgn_d   = msgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              state_d = S_MUL;
              cnt_d   = CNT_W'(MUL_LAT - 1);
              a_d     = A;
              b_d     = B;
              msgn_d  = (op == MD_MULT);
            end
            MD_DIV, MD_DIVU: begin
              state_d  = S_DIV;
              cnt_d    = CNT_W'(WIDTH - 1);
              div_load = 1'b1;
              qneg_d   = is_div & (A[WIDTH-1] ^ B[WIDTH-1]);
              rneg_d   = is_div & A[WIDTH-1];
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = product;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          lo_d = qneg_q ? (WIDTH'(0) - quo) : quo;
          hi_d = rneg_q ? (WIDTH'(0) - rem) : rem;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      msgn_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      msgn_q  <= msgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int n_pass = 0;
  int n_total = 0;

  md_unit #(.MUL_LAT(5), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    issue(o, a, b);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (HI !== 32'h0) $display("FAIL reset_hi: got %h want 00000000", HI); else n_pass++;
    n_total++; if (LO !== 32'h0) $display("FAIL reset_lo: got %h want 00000000", LO); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_mult;
    int cyc;
    run_op(MD_MULT, 32'hFFFFFFFF, 32'd2, cyc);
    n_total++; if (cyc !== 5) $display("FAIL mult_busy_cycles: got %0d want 5", cyc); else n_pass++;
    n_total++; if (HI !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", HI); else n_pass++;
    n_total++; if (LO !== 32'hFFFFFFFE) $display("FAIL mult_lo: got %h want fffffffe", LO); else n_pass++;
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, cyc);
    n_total++; if (cyc !== 5) $display("FAIL multu_busy_cycles: got %0d want 5", cyc); else n_pass++;
    n_total++; if (HI !== 32'h00000001) $display("FAIL multu_hi: got %h want 00000001", HI); else n_pass++;
    n_total++; if (LO !== 32'hFFFFFFFE) $display("FAIL multu_lo: got %h want fffffffe", LO); else n_pass++;
  endtask

  task automatic test_div;
    int cyc;
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    n_total++; if (cyc !== 33) $display("FAIL div_busy_cycles: got %0d want 33", cyc); else n_pass++;
    n_total++; if (LO !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h want fffffffd", LO); else n_pass++;
    n_total++; if (HI !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h want ffffffff", HI); else n_pass++;
    run_op(MD_DIVU, 32'd100, 32'd7, cyc);
    n_total++; if (cyc !== 33) $display("FAIL divu_busy_cycles: got %0d want 33", cyc); else n_pass++;
    n_total++; if (LO !== 32'd14) $display("FAIL divu_lo: got %h want 0000000e", LO); else n_pass++;
    n_total++; if (HI !== 32'd2) $display("FAIL divu_hi: got %h want 00000002", HI); else n_pass++;
  endtask

  task automatic test_div_boundaries;
    int cyc;
    run_op(MD_DIVU, 32'h12345678, 32'd0, cyc);
    n_total++; if (LO !== 32'hFFFFFFFF) $display("FAIL divzero_lo: got %h want ffffffff", LO); else n_pass++;
    n_total++; if (HI !== 32'h12345678) $display("FAIL divzero_hi: got %h want 12345678", HI); else n_pass++;
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    n_total++; if (LO !== 32'h80000000) $display("FAIL divovf_lo: got %h want 80000000", LO); else n_pass++;
    n_total++; if (HI !== 32'h0) $display("FAIL divovf_hi: got %h want 00000000", HI); else n_pass++;
  endtask

  task automatic test_mthi_mtlo;
    issue(MD_MTHI, 32'hDEADBEEF, 32'h0);
    n_total++; if (HI !== 32'hDEADBEEF) $display("FAIL mthi_hi: got %h want deadbeef", HI); else n_pass++;
    n_total++; if (LO !== 32'h80000000) $display("FAIL mthi_lo_kept: got %h want 80000000", LO); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", busy); else n_pass++;
    issue(MD_MTLO, 32'h0BADF00D, 32'h0);
    n_total++; if (LO !== 32'h0BADF00D) $display("FAIL mtlo_lo: got %h want 0badf00d", LO); else n_pass++;
    n_total++; if (HI !== 32'hDEADBEEF) $display("FAIL mtlo_hi_kept: got %h want deadbeef", HI); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mtlo_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_start_while_busy;
    int cyc;
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (cyc == 5) begin
        start = 1'b1; op = MD_MULT; A = 32'd3; B = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_total++; if (cyc !== 33) $display("FAIL ignored_busy_cycles: got %0d want 33", cyc); else n_pass++;
    n_total++; if (LO !== 32'hFFFFFFFD) $display("FAIL ignored_lo: got %h want fffffffd", LO); else n_pass++;
    n_total++; if (HI !== 32'hFFFFFFFF) $display("FAIL ignored_hi: got %h want ffffffff", HI); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL ignored_no_restart: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_cancel;
    issue(MD_MTHI, 32'd1, 32'd0);
    issue(MD_MTLO, 32'd2, 32'd0);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL cancel_div_pre_busy: got %b want 1", busy); else n_pass++;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL cancel_div_busy: got %b want 0", busy); else n_pass++;
    repeat (40) @(negedge clk);
    n_total++; if (HI !== 32'd1) $display("FAIL cancel_div_hi: got %h want 00000001", HI); else n_pass++;
    n_total++; if (LO !== 32'd2) $display("FAIL cancel_div_lo: got %h want 00000002", LO); else n_pass++;

    issue(MD_MULT, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL cancel_mul_pre_busy: got %b want 1", busy); else n_pass++;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL cancel_mul_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (HI !== 32'd1) $display("FAIL cancel_mul_hi: got %h want 00000001", HI); else n_pass++;
    n_total++; if (LO !== 32'd2) $display("FAIL cancel_mul_lo: got %h want 00000002", LO); else n_pass++;

    @(negedge clk);
    start = 1'b1; op = MD_MTHI; A = 32'd5; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    n_total++; if (HI !== 32'd1) $display("FAIL cancel_idle_mthi: got %h want 00000001", HI); else n_pass++;

    issue(3'd6, 32'hAAAA5555, 32'h1);
    n_total++; if (busy !== 1'b0) $display("FAIL badop_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (HI !== 32'd1 || LO !== 32'd2)
      $display("FAIL badop_hilo: got %h/%h want 00000001/00000002", HI, LO); else n_pass++;
  endtask

  task automatic test_async_reset;
    int cyc;
    issue(MD_MULT, 32'hFFFFFFFF, 32'd2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (HI !== 32'h0) $display("FAIL arst_hi: got %h want 00000000", HI); else n_pass++;
    n_total++; if (LO !== 32'h0) $display("FAIL arst_lo: got %h want 00000000", LO); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    run_op(MD_MULTU, 32'd3, 32'd5, cyc);
    n_total++; if (cyc !== 5) $display("FAIL arst_multu_cycles: got %0d want 5", cyc); else n_pass++;
    n_total++; if (LO !== 32'd15) $display("FAIL arst_multu_lo: got %h want 0000000f", LO); else n_pass++;
    n_total++; if (HI !== 32'd0) $display("FAIL arst_multu_hi: got %h want 00000000", HI); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_boundaries;
    test_mthi_mtlo;
    test_start_while_busy;
    test_cancel;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
